// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: bus widths, reset PC,
// instruction field bounds and the fetch state encoding.
package cpu_pkg;

  localparam int          ADDR_WIDTH  = 28;
  localparam int          DATA_WIDTH  = 32;
  localparam int unsigned RESET_PC    = 'h100;

  localparam int OPC_MSB     = 31;
  localparam int OPC_LSB     = 28;
  localparam int OPERAND_MSB = 27;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    VALID
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the synchronous RAM and hands
// instructions to decode. Define FETCH_COUNT_EN to build the delivered-instruction counter.
module fetch_unit #(
  parameter int                    ADDR_WIDTH  = cpu_pkg::ADDR_WIDTH,
  parameter int                    DATA_WIDTH  = cpu_pkg::DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(cpu_pkg::RESET_PC),
  parameter int                    MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_cs,
  output logic                  mem_oe,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [31:0]           fetch_count
);

  import cpu_pkg::*;

  // state | meaning
  // IDLE  | no request outstanding, waiting for run
  // REQ   | RAM strobes and address presented this cycle
  // WAIT  | strobes held, counting down to the data cycle
  // VALID | instruction offered to decode until accepted
  localparam logic [1:0] LAT_LOAD = 2'(MEM_LATENCY - 1);

  fetch_state_e          state, state_next;
  logic [ADDR_WIDTH-1:0] pc, pc_next;
  logic [1:0]            lat_cnt;
  logic                  capture;
  logic                  handshake;

  assign handshake = instr_valid & instr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    capture    = 1'b0;
    unique case (state)
      IDLE:  if (run) state_next = REQ;
      REQ:   state_next = WAIT;
      WAIT:  if (lat_cnt == 2'd0) begin
               capture    = 1'b1;
               pc_next    = pc + ADDR_WIDTH'(1);
               state_next = VALID;
             end
      VALID: if (handshake) state_next = run ? REQ : IDLE;
    endcase
    // A redirect wins over everything, including a capture in the same cycle.
    if (redirect_valid) begin
      capture    = 1'b0;
      pc_next    = redirect_pc;
      state_next = run ? REQ : IDLE;
    end
  end

  // RAM strobes are registered from the next state so they are live during REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      mem_addr    <= '0;
      mem_cs      <= 1'b0;
      mem_oe      <= 1'b0;
      lat_cnt     <= 2'd0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      pc     <= pc_next;
      mem_cs <= (state_next == REQ) || (state_next == WAIT);
      mem_oe <= (state_next == REQ) || (state_next == WAIT);
      if (state_next == REQ) mem_addr <= pc_next;

      if (state == REQ)                         lat_cnt <= LAT_LOAD;
      else if (state == WAIT && lat_cnt != 2'd0) lat_cnt <= lat_cnt - 2'd1;

      if (capture) begin
        instr       <= mem_rdata;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
      end else if (handshake || redirect_valid) begin
        instr_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         fetch_cnt <= '0;
    else if (handshake) fetch_cnt <= fetch_cnt + 32'd1;
  end

  assign fetch_count = fetch_cnt;
`else
  assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// checked against a transaction-level PC/instruction model.
module tb_fetch_unit;

  localparam int AW  = 28;
  localparam int DW  = 32;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_cs;
  logic          mem_oe;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic [31:0]   fetch_count;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] seed = 32'h1234_5678;

  fetch_unit #(.MEM_LATENCY(LAT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .run            (run),
    .mem_addr       (mem_addr),
    .mem_cs         (mem_cs),
    .mem_oe         (mem_oe),
    .mem_rdata      (mem_rdata),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [AW-1:0] a);
    if (a == 28'h100) return 32'h2000_0113;
    return (32'(a) * 32'h9E37_79B1) ^ seed;
  endfunction

  // Synchronous RAM: data appears LAT cycles after the strobed cycle.
  logic [DW-1:0] rd_pipe [LAT];
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= (mem_cs && mem_oe) ? ram_word(mem_addr) : 32'hDEAD_BEEF;
  end
  assign mem_rdata = rd_pipe[LAT-1];

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({mem_addr, mem_cs, mem_oe, instr, instr_pc, instr_valid, fetch_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got addr=%h cs=%b oe=%b instr=%h pc=%h v=%b cnt=%0d, expected all zero",
               mem_addr, mem_cs, mem_oe, instr, instr_pc, instr_valid, fetch_count);
    end
    run = 1'b1;
    cyc(); cyc();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({mem_addr, mem_cs, mem_oe, instr_valid} !== '0) begin
      miscompares++;
      $display("FAIL reset_midread_async: got addr=%h cs=%b oe=%b v=%b, expected 0", mem_addr, mem_cs, mem_oe, instr_valid);
    end
    run = 1'b0;
    cyc();
    rst_n = 1'b1;
    repeat (4) cyc();
    vectors++;
    if ({mem_cs, instr_valid, instr, instr_pc} !== '0) begin
      miscompares++;
      $display("FAIL reset_midread_abandon: got cs=%b v=%b instr=%h pc=%h, expected 0", mem_cs, instr_valid, instr, instr_pc);
    end
  endtask

  task automatic test_basic_fetch();
    int n;
    run = 1'b1; instr_ready = 1'b1;
    n = 0;
    do begin cyc(); n++; end while (!mem_cs && n < 20);
    vectors++;
    if (!(mem_cs === 1'b1 && mem_oe === 1'b1 && mem_addr === 28'h100)) begin
      miscompares++;
      $display("FAIL basic_req: got cs=%b oe=%b addr=%h, expected 1 1 100", mem_cs, mem_oe, mem_addr);
    end
    n = 0;
    while (!instr_valid && n < 20) begin cyc(); n++; end
    vectors++;
    if (n != LAT + 1) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d cycles, expected %0d", n, LAT + 1);
    end
    vectors++;
    if (!(instr === 32'h2000_0113 && instr_pc === 28'h100)) begin
      miscompares++;
      $display("FAIL basic_data: got instr=%h pc=%h, expected 20000113 100", instr, instr_pc);
    end
    cyc();
    vectors++;
    if (!(instr_valid === 1'b0 && mem_cs === 1'b1 && mem_addr === 28'h101)) begin
      miscompares++;
      $display("FAIL basic_next_req: got v=%b cs=%b addr=%h, expected 0 1 101", instr_valid, mem_cs, mem_addr);
    end
  endtask

  task automatic test_stall();
    int n;
    logic [DW-1:0] i0;
    logic [AW-1:0] p0;
    instr_ready = 1'b0;
    n = 0;
    while (!instr_valid && n < 20) begin cyc(); n++; end
    i0 = instr; p0 = instr_pc;
    vectors++;
    if (!(instr_valid === 1'b1 && p0 === 28'h101 && i0 === ram_word(28'h101))) begin
      miscompares++;
      $display("FAIL stall_first: got v=%b pc=%h instr=%h, expected 1 101 %h", instr_valid, p0, i0, ram_word(28'h101));
    end
    for (int k = 0; k < 5; k++) begin
      cyc();
      vectors++;
      if (!(instr_valid === 1'b1 && instr === i0 && instr_pc === p0 && mem_cs === 1'b0)) begin
        miscompares++;
        $display("FAIL stall_hold: cycle %0d got v=%b instr=%h pc=%h cs=%b, expected 1 %h %h 0",
                 k, instr_valid, instr, instr_pc, mem_cs, i0, p0);
      end
    end
    instr_ready = 1'b1;
    cyc();
    vectors++;
    if (!(instr_valid === 1'b0 && mem_cs === 1'b1 && mem_addr === p0 + 28'd1)) begin
      miscompares++;
      $display("FAIL stall_release: got v=%b cs=%b addr=%h, expected 0 1 %h", instr_valid, mem_cs, mem_addr, p0 + 28'd1);
    end
  endtask

  task automatic test_redirect_wait();
    int n;
    redirect_valid = 1'b1; redirect_pc = 28'h10F;
    cyc();
    redirect_valid = 1'b0;
    vectors++;
    if (!(mem_cs === 1'b1 && mem_addr === 28'h10F)) begin
      miscompares++;
      $display("FAIL redir_req: got cs=%b addr=%h, expected 1 10f", mem_cs, mem_addr);
    end
    cyc();
    redirect_valid = 1'b1; redirect_pc = 28'h100;
    cyc();
    redirect_valid = 1'b0;
    vectors++;
    if (!(instr_valid === 1'b0 && mem_cs === 1'b1 && mem_addr === 28'h100)) begin
      miscompares++;
      $display("FAIL redir_wait: got v=%b cs=%b addr=%h, expected 0 1 100", instr_valid, mem_cs, mem_addr);
    end
    n = 0;
    while (!instr_valid && n < 20) begin cyc(); n++; end
    vectors++;
    if (!(instr_valid === 1'b1 && instr_pc === 28'h100 && instr === 32'h2000_0113)) begin
      miscompares++;
      $display("FAIL redir_discard: got v=%b pc=%h instr=%h, expected 1 100 20000113", instr_valid, instr_pc, instr);
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] pcs [$];
    logic [DW-1:0] ins [$];
    int n;
    instr_ready = 1'b1; run = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 28'hFFF_FFFF;
    cyc();
    redirect_valid = 1'b0;
    n = 0;
    while (pcs.size() < 2 && n < 40) begin
      cyc(); n++;
      if (pcs.size() < 2 && instr_valid && instr_ready) begin
        pcs.push_back(instr_pc);
        ins.push_back(instr);
      end
    end
    vectors++;
    if (pcs.size() != 2) begin
      miscompares++;
      $display("FAIL wrap_timeout: got %0d deliveries, expected 2", pcs.size());
    end else begin
      vectors++;
      if (!(pcs[0] === 28'hFFF_FFFF && ins[0] === ram_word(28'hFFF_FFFF))) begin
        miscompares++;
        $display("FAIL wrap_top: got pc=%h instr=%h, expected fffffff %h", pcs[0], ins[0], ram_word(28'hFFF_FFFF));
      end
      vectors++;
      if (!(pcs[1] === 28'h000_0000 && ins[1] === ram_word(28'h0))) begin
        miscompares++;
        $display("FAIL wrap_zero: got pc=%h instr=%h, expected 0000000 %h", pcs[1], ins[1], ram_word(28'h0));
      end
    end
  endtask

  task automatic test_run_drop();
    int n;
    instr_ready = 1'b0; run = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 28'h200;
    cyc();
    redirect_valid = 1'b0;
    cyc();
    run = 1'b0;
    n = 0;
    while (!instr_valid && n < 20) begin cyc(); n++; end
    vectors++;
    if (!(instr_valid === 1'b1 && instr_pc === 28'h200 && instr === ram_word(28'h200))) begin
      miscompares++;
      $display("FAIL rundrop_deliver: got v=%b pc=%h instr=%h, expected 1 200 %h", instr_valid, instr_pc, instr, ram_word(28'h200));
    end
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      vectors++;
      if (!(mem_cs === 1'b0 && instr_valid === 1'b0)) begin
        miscompares++;
        $display("FAIL rundrop_idle: cycle %0d got cs=%b v=%b, expected 0 0", k, mem_cs, instr_valid);
      end
      cyc();
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] exp_pc;
    logic          pv, pr, prd;
    logic [DW-1:0] pi;
    logic [AW-1:0] ppc;
    run = 1'b1; instr_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 28'($urandom);
    exp_pc = redirect_pc;
    pv = 1'b0; pr = 1'b0; prd = 1'b1; pi = '0; ppc = '0;
    for (int c = 0; c < 1500; c++) begin
      cyc();
      if (pv && !pr && !prd) begin
        vectors++;
        if (!(instr_valid === 1'b1 && instr === pi && instr_pc === ppc)) begin
          miscompares++;
          $display("FAIL rand_hold: cycle %0d got v=%b instr=%h pc=%h, expected 1 %h %h", c, instr_valid, instr, instr_pc, pi, ppc);
        end
      end
      vectors++;
      if (mem_oe !== mem_cs) begin
        miscompares++;
        $display("FAIL rand_oe: cycle %0d got oe=%b, expected %b", c, mem_oe, mem_cs);
      end
      run            = ($urandom_range(0, 9) != 0);
      instr_ready    = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = ($urandom_range(0, 1) != 0) ? 28'($urandom) : 28'hFFF_FFFE;
      if (instr_valid && instr_ready) begin
        vectors++;
        if (!(instr_pc === exp_pc && instr === ram_word(exp_pc))) begin
          miscompares++;
          $display("FAIL rand_deliver: cycle %0d got pc=%h instr=%h, expected %h %h", c, instr_pc, instr, exp_pc, ram_word(exp_pc));
        end
        exp_pc = exp_pc + 28'd1;
      end
      if (redirect_valid) exp_pc = redirect_pc;
      pv = instr_valid; pr = instr_ready; prd = redirect_valid; pi = instr; ppc = instr_pc;
    end
    cyc();
    redirect_valid = 1'b0; instr_ready = 1'b0;
  endtask

  task automatic test_fetch_count();
    int hs, n;
    logic [31:0] exp_cnt;
    do_reset();
    run = 1'b1; instr_ready = 1'b1;
    hs = 0; n = 0;
    while (hs < 23 && n < 1000) begin
      cyc(); n++;
      if (instr_valid && instr_ready) begin
        if (hs == 22) begin
          redirect_valid = 1'b1; redirect_pc = 28'h300; run = 1'b0;
        end
        hs++;
      end
    end
    cyc();
    redirect_valid = 1'b0; instr_ready = 1'b0;
    repeat (3) cyc();
`ifdef FETCH_COUNT_EN
    exp_cnt = 32'(hs);
`else
    exp_cnt = 32'd0;
`endif
    vectors++;
    if (fetch_count !== exp_cnt) begin
      miscompares++;
      $display("FAIL fetch_count: got %0d, expected %0d (handshakes %0d)", fetch_count, exp_cnt, hs);
    end
    vectors++;
    if (!(instr_valid === 1'b0 && mem_cs === 1'b0)) begin
      miscompares++;
      $display("FAIL count_idle: got v=%b cs=%b, expected 0 0", instr_valid, mem_cs);
    end
  endtask

  initial begin
    seed = $urandom;
    test_reset();
    test_basic_fetch();
    test_stall();
    test_redirect_wait();
    test_wrap();
    test_run_drop();
    test_random();
    test_fetch_count();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish within 1 ms");
    $fatal(1);
  end

endmodule
